// File: rtl/beamformer_pkg.sv
// Shared types for the beamformer SPI transmit path.
package beamformer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SETUP,
        SHIFT,
        GAP
    } spi_tx_state_e;

    localparam int SPI_MODE = 0;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: tick pulses every CLK_DIV cycles while run is high.
// The first interval after load is one cycle longer, giving MOSI extra setup before the first SCLK rise.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] FIRST_CNT  = 8'(CLK_DIV);
    localparam logic [7:0] RELOAD_CNT = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = run && (cnt_q == 8'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = FIRST_CNT;
        end else if (tick) begin
            cnt_d = RELOAD_CNT;
        end else if (run) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/beamformer_spi_tx.sv
// Pops {addr,data} words from one beamformer FIFO and sends each as a mode-0, MSB-first SPI frame.
// Frame holds cs_n low 1+CLK_DIV*(1+2*FRAME_BITS) cycles; FIFO is read only when not empty and enabled.
module beamformer_spi_tx
    import beamformer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    input  logic [ADDR_WIDTH-1:0] fifo_raddr,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  spi_cs_n,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_count
);

    localparam int FRAME_BITS = ADDR_WIDTH + DATA_WIDTH;
    localparam int BCW        = $clog2(FRAME_BITS + 1);

    localparam logic [BCW-1:0] BIT_END  = BCW'(FRAME_BITS);
    localparam logic [7:0]     GAP_LAST = 8'(CS_GAP - 1);

    spi_tx_state_e         state_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [7:0]            gap_cnt_q;
    logic                  fifo_ren_q;
    logic                  cs_n_q;
    logic                  sclk_q;
    logic                  mosi_q;
    logic                  busy_q;
    logic                  frame_done_q;
    logic [15:0]           frame_count_q;

    logic div_load;
    logic div_run;
    logic div_tick;

    assign div_load = (state_q == LOAD);
    assign div_run  = (state_q == SETUP) || (state_q == SHIFT);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .load (div_load),
        .run  (div_run),
        .tick (div_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= 8'd0;
            fifo_ren_q    <= 1'b0;
            cs_n_q        <= 1'b1;
            sclk_q        <= 1'b0;
            mosi_q        <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            fifo_ren_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        state_q    <= FETCH;
                        fifo_ren_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    shreg_q   <= {fifo_raddr, fifo_rdata};
                    mosi_q    <= fifo_raddr[ADDR_WIDTH-1];
                    cs_n_q    <= 1'b0;
                    bit_cnt_q <= '0;
                    state_q   <= SETUP;
                end
                SETUP: begin
                    if (div_tick) begin
                        sclk_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_tick) begin
                        if (sclk_q) begin
                            // Falling edge: present the next bit; zeros fill in after the LSB.
                            sclk_q    <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                            shreg_q   <= shreg_q << 1;
                            mosi_q    <= shreg_q[FRAME_BITS-2];
                        end else if (bit_cnt_q == BIT_END) begin
                            cs_n_q        <= 1'b1;
                            mosi_q        <= 1'b0;
                            frame_done_q  <= 1'b1;
                            frame_count_q <= frame_count_q + 16'd1;
                            gap_cnt_q     <= GAP_LAST;
                            state_q       <= GAP;
                        end else begin
                            sclk_q <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 8'd0) begin
                        if (enable && !fifo_empty) begin
                            state_q    <= FETCH;
                            fifo_ren_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_ren    = fifo_ren_q;
    assign spi_cs_n    = cs_n_q;
    assign spi_sclk    = sclk_q;
    assign spi_mosi    = mosi_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_beamformer_spi_tx.sv
// Directed bench for beamformer_spi_tx: CLK_DIV=2 instance for framing/flow tests, CLK_DIV=1 instance for wrap.
module tb_beamformer_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // DUT A (CLK_DIV=2) and its FIFO model
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [31:0] fifo_raddr = 32'hDEAD_BEEF;
    logic [31:0] fifo_rdata = 32'hDEAD_BEEF;
    logic        spi_cs_n, spi_sclk, spi_mosi, busy, frame_done;
    logic [15:0] frame_count;

    beamformer_spi_tx #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CLK_DIV(2), .CS_GAP(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
        .fifo_raddr(fifo_raddr), .fifo_rdata(fifo_rdata), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    logic [63:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    bit pop_empty = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_ren) begin
            if (wr_ptr == rd_ptr) begin
                pop_empty <= 1'b1;
            end else begin
                {fifo_raddr, fifo_rdata} <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [63:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    // DUT B (CLK_DIV=1)
    logic        enable1, empty1, ren1, cs1, sclk1, mosi1, busy1, done1;
    logic [31:0] raddr1 = 32'h1234_5678;
    logic [31:0] rdata1 = 32'h9ABC_DEF0;
    logic [15:0] count1;

    beamformer_spi_tx #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CLK_DIV(1), .CS_GAP(2)) dut1 (
        .clk(clk), .rst(rst), .enable(enable1), .fifo_empty(empty1), .fifo_ren(ren1),
        .fifo_raddr(raddr1), .fifo_rdata(rdata1), .spi_cs_n(cs1), .spi_sclk(sclk1),
        .spi_mosi(mosi1), .busy(busy1), .frame_done(done1), .frame_count(count1)
    );

    // Monitors, sampled on the falling edge
    int ren_cnt, done_cnt, bits, low_len, last_low, high_len, falls;
    int gaps [0:7];
    logic [63:0] cap;
    logic cs_prev = 1'b1, sclk_prev = 1'b0;
    bit win = 1'b0, viol = 1'b0;

    always @(negedge clk) begin
        if (fifo_ren) ren_cnt++;
        if (frame_done) begin
            done_cnt++;
            check_eq("done_on_cs_rise", 64'({cs_prev, spi_cs_n}), 64'b01);
        end
        if (!spi_cs_n) begin
            if (cs_prev) begin
                if (falls < 8) gaps[falls] = high_len;
                falls++;
            end
            low_len++;
        end else begin
            if (!cs_prev) begin
                last_low = low_len;
                low_len  = 0;
                high_len = 0;
            end
            high_len++;
        end
        if (spi_sclk && !sclk_prev) begin
            cap = {cap[62:0], spi_mosi};
            bits++;
        end
        if (win && (fifo_ren || !spi_cs_n || spi_sclk || busy)) viol = 1'b1;
        cs_prev   = spi_cs_n;
        sclk_prev = spi_sclk;
    end

    int cyc = 0;
    int ren1_cnt, done1_cnt, low1_len, last_low1, last_rise1, per_min, per_max;
    logic cs1_prev = 1'b1, sclk1_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (ren1) ren1_cnt++;
        if (done1) done1_cnt++;
        if (!cs1) begin
            low1_len++;
        end else if (!cs1_prev) begin
            last_low1 = low1_len;
            low1_len  = 0;
        end
        if (sclk1 && !sclk1_prev) begin
            if (last_rise1 > 0) begin
                if (cyc - last_rise1 < per_min) per_min = cyc - last_rise1;
                if (cyc - last_rise1 > per_max) per_max = cyc - last_rise1;
            end
            last_rise1 = cyc;
        end
        cs1_prev   = cs1;
        sclk1_prev = sclk1;
    end

    task automatic clear_mon();
        @(posedge clk);
        #1;
        ren_cnt = 0; done_cnt = 0; bits = 0; low_len = 0; last_low = 0;
        high_len = 0; falls = 0; cap = '0; viol = 1'b0;
        ren1_cnt = 0; done1_cnt = 0; low1_len = 0; last_low1 = 0;
        last_rise1 = 0; per_min = 1000; per_max = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 64'(done_cnt >= n), 64'd1);
    endtask

    task automatic wait_bits(input int n, input int budget, input string tag);
        int k = 0;
        while (bits < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 64'(bits >= n), 64'd1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; enable1 = 1'b0; empty1 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_a", 64'({fifo_ren, spi_cs_n, spi_sclk, spi_mosi, busy, frame_done, frame_count}),
                 64'({6'b010000, 16'd0}));
        check_eq("reset_b", 64'({ren1, cs1, sclk1, mosi1, busy1, done1, count1}), 64'({6'b010000, 16'd0}));

        // 1: single frame
        clear_mon();
        @(negedge clk);
        push(64'h0000_0012_A5A5_0F0F);
        enable = 1'b1;
        wait_done(1, 2000, "t1_timeout");
        repeat (10) @(negedge clk);
        check_eq("t1_ren", 64'(ren_cnt), 64'd1);
        check_eq("t1_cs_low", 64'(last_low), 64'd259);
        check_eq("t1_bits", 64'(bits), 64'd64);
        check_eq("t1_data", cap, 64'h0000_0012_A5A5_0F0F);
        check_eq("t1_done", 64'(done_cnt), 64'd1);
        check_eq("t1_count", 64'(frame_count), 64'd1);
        check_eq("t1_busy_end", 64'(busy), 64'd0);

        // 2: three back-to-back frames
        do_reset();
        clear_mon();
        @(negedge clk);
        push(64'h1111_2222_3333_4444);
        push(64'h8000_0001_0000_0001);
        push(64'hFFFF_FFFF_0000_0000);
        enable = 1'b1;
        wait_done(3, 3000, "t2_timeout");
        repeat (10) @(negedge clk);
        check_eq("t2_ren", 64'(ren_cnt), 64'd3);
        check_eq("t2_gap1", 64'(gaps[1]), 64'd4);
        check_eq("t2_gap2", 64'(gaps[2]), 64'd4);
        check_eq("t2_bits", 64'(bits), 64'd192);
        check_eq("t2_last_data", cap, 64'hFFFF_FFFF_0000_0000);
        check_eq("t2_count", 64'(frame_count), 64'd3);

        // 3: enabled but empty
        do_reset();
        clear_mon();
        enable = 1'b1;
        win = 1'b1;
        repeat (1000) @(negedge clk);
        win = 1'b0;
        check_eq("t3_idle_viol", 64'(viol), 64'd0);
        check_eq("t3_ren", 64'(ren_cnt), 64'd0);

        // 4: enable dropped mid-frame with a second word queued
        do_reset();
        clear_mon();
        @(negedge clk);
        push(64'hCAFE_0001_1234_ABCD);
        push(64'h5555_AAAA_5555_AAAA);
        enable = 1'b1;
        wait_bits(10, 1000, "t4_bit10_timeout");
        enable = 1'b0;
        wait_done(1, 2000, "t4_timeout");
        repeat (300) @(negedge clk);
        check_eq("t4_done", 64'(done_cnt), 64'd1);
        check_eq("t4_ren", 64'(ren_cnt), 64'd1);
        check_eq("t4_data", cap, 64'hCAFE_0001_1234_ABCD);
        check_eq("t4_busy", 64'(busy), 64'd0);
        check_eq("t4_fifo_left", 64'(wr_ptr - rd_ptr), 64'd1);

        // 5: reset at bit 30 of the leftover word
        do_reset();
        clear_mon();
        enable = 1'b1;
        wait_bits(30, 1000, "t5_bit30_timeout");
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_outs", 64'({spi_cs_n, spi_sclk, spi_mosi, busy, fifo_ren, frame_done}), 64'b100000);
        rst = 1'b0;
        enable = 1'b0;
        repeat (50) @(negedge clk);
        check_eq("t5_no_done", 64'(done_cnt), 64'd0);
        check_eq("t5_count", 64'(frame_count), 64'd0);
        check_eq("t5_pop_empty", 64'(pop_empty), 64'd0);

        // 6: CLK_DIV=1 timing and frame_count wrap
        do_reset();
        @(negedge clk);
        force dut1.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut1.frame_count_q;
        @(negedge clk);
        check_eq("t6_preset", 64'(count1), 64'hFFFF);
        clear_mon();
        @(negedge clk);
        enable1 = 1'b1;
        empty1  = 1'b0;
        for (int k = 0; k < 100 && !ren1; k++) @(negedge clk);
        empty1 = 1'b1;
        for (int k = 0; k < 1000 && done1_cnt == 0; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        check_eq("t6_done", 64'(done1_cnt), 64'd1);
        check_eq("t6_ren", 64'(ren1_cnt), 64'd1);
        check_eq("t6_cs_low", 64'(last_low1), 64'd130);
        check_eq("t6_sclk_per_min", 64'(per_min), 64'd2);
        check_eq("t6_sclk_per_max", 64'(per_max), 64'd2);
        check_eq("t6_wrap", 64'(count1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
